// File: rtl/udp_arb_pkg.sv
// Shared constants and state encoding for the UDP transmit arbiter.
// Consumed by udp_tx_arb and rr_pick.
package udp_arb_pkg;

    localparam int LEN_W         = 16;
    localparam int DATA_W        = 32;
    localparam int MTU_BYTES     = 1500;
    localparam int IP_HDR_BYTES  = 20;
    localparam int UDP_HDR_BYTES = 8;
    localparam int MAX_PAYLOAD   = MTU_BYTES - IP_HDR_BYTES - UDP_HDR_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // A payload is legal when it is non-empty and fits in one frame.
    function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                    input logic [LEN_W-1:0] max_len);
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/udp_tx_arb_rr_pick.sv
// Combinational round-robin search: first set req bit strictly after ptr,
// wrapping around, so the channel at ptr itself comes last.
module rr_pick
    import udp_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] pick,
    output logic              valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_CH)) begin
                sum = sum - (PTR_W+1)'(NUM_CH);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// Round-robin owner of the UDP transmit engine: one packet per grant,
// length check, inter-packet gap. Define UDP_ARB_TIMEOUT_EN for a BUSY watchdog.
module udp_tx_arb
    import udp_arb_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IPG_CYCLES  = 12,
    parameter int MAX_BYTES   = MAX_PAYLOAD,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*LEN_W-1:0]  byte_num_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        rd_en,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     drop,
    output logic                     tx_start_en,
    output logic [LEN_W-1:0]         tx_byte_num,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_req,
    input  logic                     tx_done,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam logic [15:0] GAP_LAST = (IPG_CYCLES > 0) ? 16'(IPG_CYCLES - 1) : 16'd0;
    localparam arb_state_t AFTER_PKT = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_check
        $error("udp_tx_arb: parameter out of range");
    end

    arb_state_t        state, state_nx;
    logic [PTR_W-1:0]  ptr, ptr_nx;
    logic [NUM_CH-1:0] grant_nx, done_nx;
    logic [LEN_W-1:0]  len_nx;
    logic              start_nx, drop_nx;
    logic [15:0]       gap_cnt, gap_nx;

    logic [NUM_CH-1:0] pick;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic [LEN_W-1:0]  pick_len;

`ifdef UDP_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] to_cnt, to_nx;
`endif

    rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    // One-hot to index, and length of the picked channel.
    always_comb begin
        pick_idx = '0;
        pick_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
            pick_len = pick_len | (byte_num_in[LEN_W*i +: LEN_W] & {LEN_W{pick[i]}});
        end
    end

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tx_data = tx_data | (data_in[DATA_W*i +: DATA_W] & {DATA_W{grant[i]}});
        end
    end

    assign rd_en = (state == ST_BUSY) ? (grant & {NUM_CH{tx_req}}) : '0;
    assign busy  = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        grant_nx = grant;
        len_nx   = tx_byte_num;
        start_nx = 1'b0;
        done_nx  = '0;
        drop_nx  = 1'b0;
        gap_nx   = gap_cnt;
`ifdef UDP_ARB_TIMEOUT_EN
        to_nx    = to_cnt;
`endif
        unique case (state)
            ST_IDLE: begin
                grant_nx = '0;
                if (pick_valid) begin
                    grant_nx = pick;
                    ptr_nx   = pick_idx;
                    len_nx   = pick_len;
                    gap_nx   = '0;
                    if (len_ok(pick_len, MAX_LEN)) begin
                        start_nx = 1'b1;
                        state_nx = ST_BUSY;
`ifdef UDP_ARB_TIMEOUT_EN
                        to_nx    = '0;
`endif
                    end else begin
                        // Rejected: grant shows for the drop cycle only.
                        done_nx  = pick;
                        drop_nx  = 1'b1;
                        state_nx = AFTER_PKT;
                    end
                end
            end
            ST_BUSY: begin
                if (tx_done) begin
                    done_nx  = grant;
                    grant_nx = '0;
                    gap_nx   = '0;
                    state_nx = AFTER_PKT;
                end
`ifdef UDP_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    done_nx  = grant;
                    drop_nx  = 1'b1;
                    grant_nx = '0;
                    gap_nx   = '0;
                    state_nx = AFTER_PKT;
                end else begin
                    to_nx = to_cnt + 16'd1;
                end
`endif
            end
            ST_GAP: begin
                grant_nx = '0;
                if (gap_cnt == GAP_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    gap_nx = gap_cnt + 16'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= PTR_W'(NUM_CH - 1);
            grant       <= '0;
            ch_done     <= '0;
            drop        <= 1'b0;
            tx_start_en <= 1'b0;
            tx_byte_num <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            grant       <= grant_nx;
            ch_done     <= done_nx;
            drop        <= drop_nx;
            tx_start_en <= start_nx;
            tx_byte_num <= len_nx;
            gap_cnt     <= gap_nx;
        end
    end

`ifdef UDP_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_nx;
        end
    end
`endif

endmodule

// File: tb/tb_udp_tx_arb.sv
// Self-checking bench for udp_tx_arb: hand-derived vector table, directed
// corner sequences, and randomized packets against a packet-level model.
module tb_udp_tx_arb;

    localparam int NCH = 4;
    localparam int IPG = 12;
    localparam int MAXB = 1472;
`ifdef UDP_ARB_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 65535;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH*16-1:0] byte_num_in = '0;
    logic [NCH*32-1:0] data_in = '0;
    logic [NCH-1:0]    grant, rd_en, ch_done;
    logic              drop, tx_start_en, busy;
    logic [15:0]       tx_byte_num;
    logic [31:0]       tx_data;
    logic              tx_req = 1'b0;
    logic              tx_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int last_ch = NCH - 1;
    logic [15:0] lw [NCH];
    logic [31:0] dw [NCH];

    always #5 clk = ~clk;

    udp_tx_arb #(
        .NUM_CH(NCH), .IPG_CYCLES(IPG), .MAX_BYTES(MAXB), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .byte_num_in(byte_num_in),
        .data_in(data_in), .grant(grant), .rd_en(rd_en), .ch_done(ch_done),
        .drop(drop), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rule: first requester strictly after the last served channel.
    function automatic int model_pick(input int last, input logic [NCH-1:0] r);
        for (int k = 1; k <= NCH; k++) begin
            if (r[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    function automatic bit model_ok(input logic [15:0] l);
        return (l >= 16'd1) && (l <= 16'(MAXB));
    endfunction

    task automatic drive_bufs();
        for (int i = 0; i < NCH; i++) begin
            byte_num_in[16*i +: 16] = lw[i];
            data_in[32*i +: 32]     = dw[i];
        end
    endtask

    task automatic wait_idle(input string name, input bit check_len);
        int cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(posedge clk); @(negedge clk);
        end
        if (check_len) check({name, "_gap_len"}, 64'(cnt), 64'(IPG));
        check({name, "_idle_grant"}, 64'(grant), 64'd0);
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    // Called at a negedge in IDLE; lw/dw must already hold channel buffers.
    task automatic run_packet(input string name, input logic [NCH-1:0] r,
                              input int exp_ch, input bit exp_ok, input int hold);
        logic [NCH-1:0] oh;
        oh = NCH'(1) << exp_ch;
        drive_bufs();
        req = r;
        @(posedge clk); @(negedge clk);
        check({name, "_grant"}, 64'(grant), 64'(oh));
        check({name, "_start"}, 64'(tx_start_en), 64'(exp_ok));
        check({name, "_drop"}, 64'(drop), 64'(!exp_ok));
        check({name, "_pick_done"}, 64'(ch_done), exp_ok ? 64'd0 : 64'(oh));
        check({name, "_byte_num"}, 64'(tx_byte_num), 64'(lw[exp_ch]));
        check({name, "_busy"}, 64'(busy), 64'd1);
        req = '0;
        last_ch = exp_ch;
        if (exp_ok) begin
            for (int i = 0; i < hold; i++) begin
                tx_req = 1'($urandom_range(0, 1));
                #1;
                check({name, "_rd_en"}, 64'(rd_en), tx_req ? 64'(oh) : 64'd0);
                check({name, "_tx_data"}, 64'(tx_data), 64'(dw[exp_ch]));
                @(posedge clk); @(negedge clk);
                check({name, "_hold_grant"}, 64'(grant), 64'(oh));
                check({name, "_start_once"}, 64'(tx_start_en), 64'd0);
            end
            tx_req = 1'b0;
            tx_done = 1'b1;
            @(posedge clk); @(negedge clk);
            tx_done = 1'b0;
            check({name, "_ch_done"}, 64'(ch_done), 64'(oh));
            check({name, "_done_grant"}, 64'(grant), 64'd0);
            check({name, "_done_drop"}, 64'(drop), 64'd0);
        end
        wait_idle(name, 1'b1);
    endtask

    typedef struct {
        logic [NCH-1:0] req;
        logic [15:0]    len;
        int             exp_ch;
        bit             exp_ok;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] r;
        int ch;
        tbl[0]  = '{4'b0010, 16'd100,  1, 1'b1};
        tbl[1]  = '{4'b1111, 16'd10,   2, 1'b1};
        tbl[2]  = '{4'b1111, 16'd10,   3, 1'b1};
        tbl[3]  = '{4'b1111, 16'd10,   0, 1'b1};
        tbl[4]  = '{4'b1111, 16'd10,   1, 1'b1};
        tbl[5]  = '{4'b0100, 16'd0,    2, 1'b0};
        tbl[6]  = '{4'b0100, 16'd1473, 2, 1'b0};
        tbl[7]  = '{4'b0100, 16'd1472, 2, 1'b1};
        tbl[8]  = '{4'b0001, 16'd1,    0, 1'b1};
        tbl[9]  = '{4'b1001, 16'd20,   3, 1'b1};
        tbl[10] = '{4'b1001, 16'd20,   0, 1'b1};

        // Reset state
        #1;
        check("rst_outputs", {grant, rd_en, ch_done, drop, tx_start_en, busy},
              64'd0);
        check("rst_byte_num", 64'(tx_byte_num), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray strobes in IDLE
        for (int i = 0; i < 4; i++) begin
            tx_req = 1'b1;
            tx_done = 1'b1;
            #1;
            check("stray_rd_en", 64'(rd_en), 64'd0);
            @(posedge clk); @(negedge clk);
            check("stray_ch_done", 64'(ch_done), 64'd0);
            check("stray_busy", 64'(busy), 64'd0);
        end
        tx_req = 1'b0;
        tx_done = 1'b0;

        // Vector table
        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < NCH; i++) begin
                lw[i] = tbl[v].len;
                dw[i] = $urandom;
            end
            run_packet($sformatf("vec%0d", v), tbl[v].req, tbl[v].exp_ch,
                       tbl[v].exp_ok, 3);
        end

        // Asynchronous reset during BUSY
        for (int i = 0; i < NCH; i++) begin
            lw[i] = 16'd50;
            dw[i] = $urandom;
        end
        drive_bufs();
        req = 4'b0100;
        @(posedge clk); @(negedge clk);
        check("rstbusy_grant", 64'(grant), 64'b0100);
        req = '0;
        tx_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rstbusy_outputs", {grant, rd_en, ch_done, drop, tx_start_en, busy},
              64'd0);
        check("rstbusy_len", 64'(tx_byte_num), 64'd0);
        check("rstbusy_data", 64'(tx_data), 64'd0);
        tx_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_ch = NCH - 1;
        @(negedge clk);

        // All channels requesting after reset: 0,1,2,3,0
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < NCH; i++) begin
                lw[i] = 16'd64;
                dw[i] = $urandom;
            end
            run_packet($sformatf("rr%0d", p), 4'b1111, p % NCH, 1'b1, 2);
        end

        // Randomized packets against the model
        for (int p = 0; p < 40; p++) begin
            r = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int i = 0; i < NCH; i++) begin
                case ($urandom_range(0, 5))
                    0:       lw[i] = 16'd0;
                    1:       lw[i] = 16'd1;
                    2:       lw[i] = 16'(MAXB);
                    3:       lw[i] = 16'(MAXB + 1);
                    4:       lw[i] = 16'hFFFF;
                    default: lw[i] = 16'($urandom_range(1, MAXB));
                endcase
                dw[i] = $urandom;
            end
            ch = model_pick(last_ch, r);
            run_packet($sformatf("rnd%0d", p), r, ch, model_ok(lw[ch]),
                       int'($urandom_range(1, 6)));
        end

`ifdef UDP_ARB_TIMEOUT_EN
        begin
            int cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                lw[i] = 16'd10;
                dw[i] = $urandom;
            end
            drive_bufs();
            req = 4'b1000;
            @(posedge clk); @(negedge clk);
            check("to_start", 64'(tx_start_en), 64'd1);
            req = '0;
            while (!drop && cnt < 200) begin
                cnt++;
                @(posedge clk); @(negedge clk);
            end
            check("to_cycles", 64'(cnt), 64'(TMO));
            check("to_ch_done", 64'(ch_done), 64'b1000);
            check("to_grant", 64'(grant), 64'd0);
            tx_done = 1'b1;
            @(posedge clk); @(negedge clk);
            tx_done = 1'b0;
            check("to_late_done", 64'(ch_done), 64'd0);
            check("to_late_drop", 64'(drop), 64'd0);
            wait_idle("to", 1'b0);
            last_ch = 3;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
- Round-robin scheduler that shares the single UDP transmit engine among NUM_CH packet sources, e.g. video channels and a command/ack channel.
- Runs in the gmii_tx_clk domain, between the per-channel packet buffers and the UDP top's tx_start_en/tx_data/tx_byte_num/tx_req/tx_done interface.
- Grants one channel per packet, routes that channel's data and read strobes, enforces a length check, and inserts an inter-packet holdoff.

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- IPG_CYCLES, 12: idle clock cycles after tx_done before the next grant (0 allowed).
- MAX_BYTES, 1472: largest legal payload in bytes (1500 MTU minus IP/UDP headers).
- TIMEOUT_CYC, 65535: BUSY watchdog limit; used only with UDP_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  gmii_tx_clk domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_CH  level request per channel; packet ready.
- byte_num_in  input  NUM_CH*16  payload length per channel; channel i occupies bits [16i+15:16i].
- data_in  input  NUM_CH*32  payload word per channel; channel i occupies bits [32i+31:32i].
- grant  output  NUM_CH  one-hot owner of the transmitter.
- rd_en  output  NUM_CH  tx_req forwarded to the granted channel only.
- ch_done  output  NUM_CH  one-cycle end-of-packet pulse to the owner.
- drop  output  1  one-cycle pulse when a packet is rejected for length.
- tx_start_en  output  1  to UDP tx, one-cycle start pulse.
- tx_byte_num  output  16  to UDP tx, latched length.
- tx_data  output  32  to UDP tx, muxed data_in of the owner.
- tx_req  input  1  UDP tx word request.
- tx_done  input  1  UDP tx packet complete.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: every output is 0, state = IDLE, rr pointer = NUM_CH-1, so channel 0 has first priority.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If req is nonzero, pick the first set bit searching upward from pointer+1, with wrap-around. All of the following are registered in the next cycle: grant = onehot(pick), pointer = pick, tx_byte_num = byte_num_in[pick].
  - If 1 <= len <= MAX_BYTES: tx_start_en is high for exactly that one cycle and the state goes to BUSY. Latency from a sampled req to tx_start_en is 1 cycle.
  - If len == 0 or len > MAX_BYTES: no tx_start_en. ch_done[pick] and drop pulse in the same cycle, grant is held for that cycle only, and the state goes to GAP.
- BUSY:
  - tx_data = data_in[owner] (combinational mux; zero when there is no grant).
  - rd_en = grant & {NUM_CH{tx_req}}.
  - When tx_done is sampled: ch_done[owner] pulses in the next cycle, grant clears in the same cycle as that pulse, and the state goes to GAP.
- GAP: the counter counts IPG_CYCLES cycles, then the state returns to IDLE. With IPG_CYCLES = 0 the state goes directly to IDLE.
- tx_done and tx_req are ignored outside BUSY; rd_en stays 0 there.
- req dropping while granted: no abort. Grant is held until tx_done.
- Simultaneous requests: strict round robin. A channel that was just served has lowest priority on the next pick.
- Asserting rst_n low in any state returns everything to the reset values immediately. An in-flight UDP frame is the UDP engine's concern.
- Lengths are 16-bit unsigned compares; no arithmetic on the data path.

Optional Feature:
- UDP_ARB_TIMEOUT_EN defined:
  - A 16-bit counter runs in BUSY. If it reaches TIMEOUT_CYC without tx_done, ch_done[owner] and drop pulse, grant clears, and the state goes to GAP.
  - A later stray tx_done is ignored.
- UDP_ARB_TIMEOUT_EN undefined: BUSY waits for tx_done indefinitely, and no counter logic is built.

Decomposition:
- Package udp_arb_pkg: state encoding (IDLE/BUSY/GAP), LEN_W=16, DATA_W=32, and MTU-derived constants.
- Sub-module rr_pick: combinational round-robin priority search. Inputs are req and pointer; outputs are the one-hot pick and a valid flag.

Test Plan:
- Single request, NUM_CH=4, req=4'b0010, len=100 → tx_start_en pulses 1 cycle after req, tx_byte_num=100, rd_en[1] mirrors tx_req, ch_done[1] pulses 1 cycle after tx_done, then 12 GAP cycles with busy=1.
- All four channels requesting continuously → grant order 0,1,2,3,0 across five packets, with no channel granted twice in a row.
- req[2] with len=0, then len=1473 → drop and ch_done[2] pulse each time, tx_start_en never asserts, GAP is entered.
- req[3] deasserted mid-BUSY, and tx_req/tx_done pulsed while in IDLE → grant stays on channel 3 until tx_done; stray strobes produce no rd_en or ch_done.
- rst_n pulsed low during BUSY → all outputs 0 asynchronously, and the next pick is channel 0.
- With UDP_ARB_TIMEOUT_EN and TIMEOUT_CYC=50, tx_done withheld → drop and ch_done pulse 50 cycles into BUSY, and a late tx_done is ignored.
